qracc_sram_bank_router: RTL and testbench
=========================================

QRACC_SRAM_BANK_ROUTER -- requirements
Module: qracc_sram_bank_router

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- NUM_BANKS, 4, number of downstream SRAM banks; power of two, at least 2.
- NUM_ROWS, 128, rows per bank.
- NUM_COLS, 32, data width.
- MAX_OUTSTANDING, 4, read-tag FIFO depth; power of two.
- Derived: BW = clog2(NUM_BANKS), RW = clog2(NUM_ROWS).

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below as name, direction, width, meaning.
- clk, in, 1, single clock; all state is on the rising edge.
- nrst, in, 1, asynchronous active-low reset.
- clear_i, in, 1, synchronous flush.
- up_rq_valid_i, in, 1, upstream request valid.
- up_rq_wr_i, in, 1, 1 = write, 0 = read.
- up_bcast_i, in, 1, broadcast write to all banks; ignored for reads.
- up_addr_i, in, BW+RW, bank index in the MSBs, row in the LSBs.
- up_wr_data_i, in, NUM_COLS, write data.
- up_rq_ready_o, out, 1, request accepted when valid and ready are both high.
- up_rd_valid_o, out, 1, read data valid.
- up_rd_data_o, out, NUM_COLS, read data.
- bk_rq_valid_o, out, NUM_BANKS, per-bank request valid.
- bk_rq_wr_o, out, NUM_BANKS, per-bank write/read.
- bk_rq_ready_i, in, NUM_BANKS, per-bank ready.
- bk_addr_o, out, RW, shared row address.
- bk_wr_data_o, out, NUM_COLS, shared write data.
- bk_rd_valid_i, in, NUM_BANKS, per-bank read return valid.
- bk_rd_data_i, in, NUM_BANKS*NUM_COLS, bank b occupies slice [b*NUM_COLS +: NUM_COLS].
- outstanding_o, out, clog2(MAX_OUTSTANDING)+1, number of reads in flight.
- err_o, out, 1, sticky protocol error.

Function
REQ-003 Routing SHALL be combinational: bk_addr_o = up_addr_i[RW-1:0]; bk_wr_data_o = up_wr_data_i; target bank = up_addr_i[BW+RW-1:RW].
- A valid downstream output SHALL never depend on a ready input of the same bank.
REQ-004 Unicast write: bk_rq_valid_o[target] = up_rq_valid_i; up_rq_ready_o = bk_rq_ready_i[target].
REQ-005 Read: bk_rq_valid_o[target] SHALL be high only when all of the following hold:
- the tag FIFO is not full;
- bank target has no read in flight (per-bank busy bit clear).
- Otherwise valid is 0 and up_rq_ready_o is 0.
REQ-006 On read acceptance the block SHALL push the target index into the tag FIFO and set busy[target].
REQ-007 Broadcast write SHALL use states IDLE and BCAST with a NUM_BANKS-bit pending mask, reset to all-ones.
- bk_rq_valid_o = up_rq_valid_i & pending.
- Each bank handshake clears its pending bit.
- up_rq_ready_o SHALL be high in the cycle where every still-pending bank is ready.
- The state SHALL enter BCAST after the first partial acceptance and return to IDLE with mask = all-ones on completion.
- While in BCAST, upstream request fields SHALL be held stable by the master.
REQ-008 Each bank SHALL have a one-entry hold register.
- bk_rd_valid_i[b] with busy[b] set captures data, unless it is bypassed (REQ-009).
- busy[b] clears on return.
REQ-009 Read return SHALL be in issue order.
- When the FIFO head bank h has data (hold[h] valid, or bk_rd_valid_i[h] this cycle), then at the next edge: up_rd_valid_o <= 1, up_rd_data_o <= that data, pop FIFO, clear hold[h].
- Latency SHALL be 1 cycle when the head bank returns directly.
- At most one upstream return SHALL occur per cycle; up_rd_valid_o is a 1-cycle pulse.
REQ-010 Simultaneous push and pop SHALL keep occupancy constant; outstanding_o = FIFO occupancy.
REQ-011 bk_rd_valid_i[b] with busy[b] clear SHALL be ignored and SHALL set err_o.
REQ-012 A request with up_bcast_i=1 and up_rq_wr_i=0 SHALL be treated as a unicast read.
REQ-013 clear_i SHALL, at the next edge, take priority over all other activity:
- empty the FIFO and clear busy and hold;
- set state IDLE and pending = all-ones;
- set up_rd_valid_o = 0 and err_o = 0.
- In-flight reads SHALL be discarded and their late returns ignored without setting err_o until the next acceptance.

Reset
REQ-014 While nrst=0, asynchronously:
- up_rd_valid_o = 0, up_rd_data_o = 0, err_o = 0, outstanding_o = 0;
- state IDLE, pending = all-ones, busy = 0, holds empty.
- bk_rq_valid_o and up_rq_ready_o SHALL be 0 when up_rq_valid_i = 0.

Verification
REQ-015 Unicast write to addr {bank 2, row 5}, bank ready -> bk_rq_valid_o = 4'b0100, bk_addr_o = 5, accepted in the same cycle.
REQ-016 Reads to bank 1, then bank 3; bank 3 returns 0xBBBB before bank 1 returns 0xAAAA -> upstream sees 0xAAAA then 0xBBBB, outstanding_o goes 2 -> 1 -> 0.
REQ-017 Broadcast write with bk_rq_ready_i = 4'b0101 in cycle 0 and 4'b1010 in cycle 1 -> pending 1010 after cycle 0, up_rq_ready_o high only in cycle 1, mask back to 1111.
REQ-018 Four reads to banks 0-3 with no returns -> fifth read held not-ready; a second read to a busy bank is blocked even when the FIFO is not full.
REQ-019 Unsolicited bk_rd_valid_i[2] -> err_o = 1 and sticky; clear_i -> err_o = 0 and outstanding_o = 0.
REQ-020 nrst asserted with 2 reads outstanding -> outputs zero immediately; after release, a new read completes normally.

Source files
------------

// File: rtl/qracc_sram_bank_router.sv
// -----------------------------------------------------------------------------
// qracc_sram_bank_router
//
// Routes one upstream SRAM request stream onto NUM_BANKS downstream banks and
// returns read data to the upstream side in issue order.
//
//   * Row address and write data are shared by all banks. The bank is selected
//     by the MSBs of up_addr_i.
//   * Unicast writes go straight to the target bank.
//   * Broadcast writes go to every bank. A pending mask records which banks
//     have not yet taken the write, so the banks may accept in different cycles.
//   * Reads push the target bank index into a tag FIFO. Each bank holds at most
//     one read in flight. A one-entry hold register per bank parks data that
//     comes back out of order until that bank reaches the FIFO head.
//
// Ports
//   clk, nrst                 clock, asynchronous active-low reset
//   clear_i                   synchronous flush of all read tracking and err_o
//   up_rq_*/up_addr_i/...     upstream request channel (valid/ready)
//   up_rd_valid_o/_data_o     upstream read return (1-cycle pulse)
//   bk_rq_valid_o/_wr_o       per-bank request valid and write flag
//   bk_rq_ready_i             per-bank request ready
//   bk_addr_o/bk_wr_data_o    shared row address and write data
//   bk_rd_valid_i/_data_i     per-bank read return; bank b in slice b*NUM_COLS
//   outstanding_o             number of reads in flight (tag FIFO occupancy)
//   err_o                     sticky: a bank returned data it was not asked for
// -----------------------------------------------------------------------------
module qracc_sram_bank_router #(
    parameter int  NUM_BANKS       = 4,
    parameter int  NUM_ROWS        = 128,
    parameter int  NUM_COLS        = 32,
    parameter int  MAX_OUTSTANDING = 4,
    localparam int BW              = $clog2(NUM_BANKS),
    localparam int RW              = $clog2(NUM_ROWS),
    localparam int OW              = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          clear_i,
    input  logic                          up_rq_valid_i,
    input  logic                          up_rq_wr_i,
    input  logic                          up_bcast_i,
    input  logic [BW+RW-1:0]              up_addr_i,
    input  logic [NUM_COLS-1:0]           up_wr_data_i,
    output logic                          up_rq_ready_o,
    output logic                          up_rd_valid_o,
    output logic [NUM_COLS-1:0]           up_rd_data_o,
    output logic [NUM_BANKS-1:0]          bk_rq_valid_o,
    output logic [NUM_BANKS-1:0]          bk_rq_wr_o,
    input  logic [NUM_BANKS-1:0]          bk_rq_ready_i,
    output logic [RW-1:0]                 bk_addr_o,
    output logic [NUM_COLS-1:0]           bk_wr_data_o,
    input  logic [NUM_BANKS-1:0]          bk_rd_valid_i,
    input  logic [NUM_BANKS*NUM_COLS-1:0] bk_rd_data_i,
    output logic [OW-1:0]                 outstanding_o,
    output logic                          err_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_BANKS-1:0]  pending_q, pending_d;
    logic [NUM_BANKS-1:0]  busy_q;
    logic [NUM_BANKS-1:0]  hold_v_q;
    logic [NUM_COLS-1:0]   hold_d_q [NUM_BANKS];
    logic [BW-1:0]         tag_q    [MAX_OUTSTANDING];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]         count_q;
    // Set by clear_i. While set, a return from an idle bank is taken to be the
    // late answer to a discarded read and does not raise err_o.
    logic                  flushed_q;

    logic [BW-1:0]         target;
    logic                  is_bcast;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  rd_ok;
    logic                  rd_accept;
    logic                  up_accept;
    logic [NUM_COLS-1:0]   rd_data [NUM_BANKS];
    logic [BW-1:0]         head;
    logic                  head_hit;
    logic                  head_from_hold;
    logic [NUM_COLS-1:0]   head_data;
    logic [NUM_BANKS-1:0]  head_oh, target_oh;
    logic [NUM_BANKS-1:0]  ret_ok, unsolicited, capture;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // ---------------------------------------------------------------- routing
    assign target        = up_addr_i[BW+RW-1:RW];
    assign bk_addr_o     = up_addr_i[RW-1:0];
    assign bk_wr_data_o  = up_wr_data_i;
    assign outstanding_o = count_q;

    // A broadcast flag on a read is ignored, so the request is routed as a unicast read.
    assign is_bcast   = up_rq_wr_i & up_bcast_i;
    assign fifo_full  = (count_q == OW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    // A bank whose returned data is still parked in its hold register counts
    // as busy. Otherwise a second return from that bank could overwrite data
    // that has not yet gone upstream.
    assign rd_ok      = !fifo_full && !busy_q[target] && !hold_v_q[target];

    // Request side and broadcast FSM. Downstream valids come only from
    // upstream valid and local state, never from a bank ready.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
        bk_rq_valid_o = '0;
        bk_rq_wr_o    = '0;
        up_rq_ready_o = 1'b0;
        state_d       = state_q;
        pending_d     = pending_q;

        if (is_bcast) begin
            bk_rq_valid_o = {NUM_BANKS{up_rq_valid_i}} & pending_q;
            bk_rq_wr_o    = pending_q;
            // Complete once every bank still owing the write is ready this cycle.
            up_rq_ready_o = up_rq_valid_i && ((pending_q & ~bk_rq_ready_i) == '0);
            if (up_rq_valid_i) begin
                if ((pending_q & ~bk_rq_ready_i) == '0) begin
                    state_d   = IDLE;
                    pending_d = '1;
                end else if ((pending_q & bk_rq_ready_i) != '0) begin
                    state_d   = BCAST;
                    pending_d = pending_q & ~bk_rq_ready_i;
                end
            end
        end else if (up_rq_wr_i) begin
            bk_rq_valid_o[target] = up_rq_valid_i;
            bk_rq_wr_o[target]    = 1'b1;
            up_rq_ready_o         = up_rq_valid_i & bk_rq_ready_i[target];
        end else begin
            bk_rq_valid_o[target] = up_rq_valid_i & rd_ok;
            up_rq_ready_o         = up_rq_valid_i & rd_ok & bk_rq_ready_i[target];
        end
    end

    assign up_accept = up_rq_valid_i & up_rq_ready_o;
    assign rd_accept = up_accept & ~up_rq_wr_i;

    // ----------------------------------------------------------- return side
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_data[b] = bk_rd_data_i[b*NUM_COLS +: NUM_COLS];
        end
    end

    assign head           = tag_q[rd_ptr_q];
    assign head_from_hold = !fifo_empty && hold_v_q[head];
    assign head_hit       = !fifo_empty &&
                            (hold_v_q[head] || (bk_rd_valid_i[head] && busy_q[head]));
    assign head_data      = hold_v_q[head] ? hold_d_q[head] : rd_data[head];

    always_comb begin
        head_oh           = '0;
        head_oh[head]     = 1'b1;
        target_oh         = '0;
        target_oh[target] = 1'b1;
    end

    assign ret_ok      = bk_rd_valid_i & busy_q;
    assign unsolicited = bk_rd_valid_i & ~busy_q;
    // A return from the head bank goes straight upstream. Every other expected
    // return is parked in that bank's hold register.
    assign capture     = ret_ok & ~({NUM_BANKS{head_hit & ~head_from_hold}} & head_oh);

    // NOTE: sequential state updates use non-blocking assignment only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            pending_q     <= '1;
            busy_q        <= '0;
            hold_v_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            up_rd_valid_o <= 1'b0;
            up_rd_data_o  <= '0;
            err_o         <= 1'b0;
            flushed_q     <= 1'b0;
        end else if (clear_i) begin
            state_q       <= IDLE;
            pending_q     <= '1;
            busy_q        <= '0;
            hold_v_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            up_rd_valid_o <= 1'b0;
            err_o         <= 1'b0;
            flushed_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            busy_q        <= (busy_q & ~bk_rd_valid_i) | (rd_accept ? target_oh : '0);
            hold_v_q      <= (hold_v_q | capture) & ~(head_from_hold ? head_oh : '0);
            up_rd_valid_o <= head_hit;
            if (head_hit) begin
                up_rd_data_o <= head_data;
                rd_ptr_q     <= ptr_inc(rd_ptr_q);
            end
            if (rd_accept) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            count_q <= count_q + OW'(rd_accept) - OW'(head_hit);
            if ((unsolicited != '0) && !flushed_q) begin
                err_o <= 1'b1;
            end
            if (up_accept) begin
                flushed_q <= 1'b0;
            end
        end
    end

    // NOTE: storage arrays are not reset. Their contents are only read while count_q or hold_v_q, which are reset, marks them valid.
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            tag_q[wr_ptr_q] <= target;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (capture[b]) begin
                hold_d_q[b] <= rd_data[b];
            end
        end
    end

endmodule

// File: tb/tb_qracc_sram_bank_router.sv
module tb_qracc_sram_bank_router;

    localparam int NB = 4;
    localparam int NR = 128;
    localparam int NC = 32;
    localparam int MO = 4;
    localparam int BW = 2;
    localparam int RW = 7;
    localparam int OW = 3;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              clear_i = 1'b0;
    logic              up_rq_valid_i = 1'b0;
    logic              up_rq_wr_i = 1'b0;
    logic              up_bcast_i = 1'b0;
    logic [BW+RW-1:0]  up_addr_i = '0;
    logic [NC-1:0]     up_wr_data_i = '0;
    logic              up_rq_ready_o;
    logic              up_rd_valid_o;
    logic [NC-1:0]     up_rd_data_o;
    logic [NB-1:0]     bk_rq_valid_o;
    logic [NB-1:0]     bk_rq_wr_o;
    logic [NB-1:0]     bk_rq_ready_i = '0;
    logic [RW-1:0]     bk_addr_o;
    logic [NC-1:0]     bk_wr_data_o;
    logic [NB-1:0]     bk_rd_valid_i = '0;
    logic [NB*NC-1:0]  bk_rd_data_i = '0;
    logic [OW-1:0]     outstanding_o;
    logic              err_o;

    int n_vec = 0;
    int n_err = 0;

    qracc_sram_bank_router #(
        .NUM_BANKS(NB), .NUM_ROWS(NR), .NUM_COLS(NC), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .nrst(nrst), .clear_i(clear_i),
        .up_rq_valid_i(up_rq_valid_i), .up_rq_wr_i(up_rq_wr_i), .up_bcast_i(up_bcast_i),
        .up_addr_i(up_addr_i), .up_wr_data_i(up_wr_data_i), .up_rq_ready_o(up_rq_ready_o),
        .up_rd_valid_o(up_rd_valid_o), .up_rd_data_o(up_rd_data_o),
        .bk_rq_valid_o(bk_rq_valid_o), .bk_rq_wr_o(bk_rq_wr_o), .bk_rq_ready_i(bk_rq_ready_i),
        .bk_addr_o(bk_addr_o), .bk_wr_data_o(bk_wr_data_o),
        .bk_rd_valid_i(bk_rd_valid_i), .bk_rd_data_i(bk_rd_data_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge. Outputs are sampled there too,
    // or 1 unit later for combinational paths.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        up_rq_valid_i = 1'b0;
        up_rq_wr_i    = 1'b0;
        up_bcast_i    = 1'b0;
        bk_rd_valid_i = '0;
        clear_i       = 1'b0;
    endtask

    task automatic set_req(input logic wr, input logic bc, input int bank, input int row,
                           input logic [NC-1:0] data);
        up_rq_valid_i = 1'b1;
        up_rq_wr_i    = wr;
        up_bcast_i    = bc;
        up_addr_i     = {bank[BW-1:0], row[RW-1:0]};
        up_wr_data_i  = data;
    endtask

    task automatic test_reset();
        idle_inputs();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (up_rd_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got=%b exp=0", up_rd_valid_o); end
        n_vec++; if (up_rd_data_o !== '0) begin n_err++; $display("FAIL reset_rd_data got=%h exp=0", up_rd_data_o); end
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err_o); end
        n_vec++; if (outstanding_o !== 3'd0) begin n_err++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); end
        n_vec++; if (bk_rq_valid_o !== 4'b0000 || up_rq_ready_o !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_req got valid=%b ready=%b exp 0000/0", bk_rq_valid_o, up_rq_ready_o); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_unicast_write();
        bk_rq_ready_i = 4'b1111;
        set_req(1'b1, 1'b0, 2, 5, 32'hCAFE_0005);
        #1;
        n_vec++; if (bk_rq_valid_o !== 4'b0100) begin n_err++; $display("FAIL uwr_valid got=%b exp=0100", bk_rq_valid_o); end
        n_vec++; if (bk_addr_o !== 7'd5) begin n_err++; $display("FAIL uwr_addr got=%0d exp=5", bk_addr_o); end
        n_vec++; if (up_rq_ready_o !== 1'b1) begin n_err++; $display("FAIL uwr_ready got=%b exp=1", up_rq_ready_o); end
        n_vec++; if (bk_rq_wr_o[2] !== 1'b1 || bk_wr_data_o !== 32'hCAFE_0005) begin
            n_err++; $display("FAIL uwr_wr got wr=%b data=%h exp 1/cafe0005", bk_rq_wr_o[2], bk_wr_data_o); end
        bk_rq_ready_i = 4'b1011;
        #1;
        n_vec++; if (up_rq_ready_o !== 1'b0 || bk_rq_valid_o !== 4'b0100) begin
            n_err++; $display("FAIL uwr_not_ready got ready=%b valid=%b exp 0/0100", up_rq_ready_o, bk_rq_valid_o); end
        up_rq_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_read_order();
        bk_rq_ready_i = 4'b1111;
        set_req(1'b0, 1'b0, 1, 3, '0);
        #1;
        n_vec++; if (up_rq_ready_o !== 1'b1 || bk_rq_valid_o !== 4'b0010) begin
            n_err++; $display("FAIL ord_rd1 got ready=%b valid=%b exp 1/0010", up_rq_ready_o, bk_rq_valid_o); end
        tick();
        set_req(1'b0, 1'b0, 3, 9, '0);
        #1;
        n_vec++; if (up_rq_ready_o !== 1'b1) begin n_err++; $display("FAIL ord_rd3 got ready=%b exp=1", up_rq_ready_o); end
        tick();
        idle_inputs();
        n_vec++; if (outstanding_o !== 3'd2) begin n_err++; $display("FAIL ord_out2 got=%0d exp=2", outstanding_o); end
        bk_rd_valid_i = 4'b1000;
        bk_rd_data_i[3*NC +: NC] = 32'h0000_BBBB;
        tick();
        bk_rd_valid_i = '0;
        n_vec++; if (up_rd_valid_o !== 1'b0 || outstanding_o !== 3'd2) begin
            n_err++; $display("FAIL ord_held got rdv=%b out=%0d exp 0/2", up_rd_valid_o, outstanding_o); end
        bk_rd_valid_i = 4'b0010;
        bk_rd_data_i[1*NC +: NC] = 32'h0000_AAAA;
        tick();
        bk_rd_valid_i = '0;
        n_vec++; if (up_rd_valid_o !== 1'b1 || up_rd_data_o !== 32'h0000_AAAA || outstanding_o !== 3'd1) begin
            n_err++; $display("FAIL ord_first got rdv=%b data=%h out=%0d exp 1/aaaa/1", up_rd_valid_o, up_rd_data_o, outstanding_o); end
        tick();
        n_vec++; if (up_rd_valid_o !== 1'b1 || up_rd_data_o !== 32'h0000_BBBB || outstanding_o !== 3'd0) begin
            n_err++; $display("FAIL ord_second got rdv=%b data=%h out=%0d exp 1/bbbb/0", up_rd_valid_o, up_rd_data_o, outstanding_o); end
        tick();
        n_vec++; if (up_rd_valid_o !== 1'b0 || err_o !== 1'b0) begin
            n_err++; $display("FAIL ord_pulse got rdv=%b err=%b exp 0/0", up_rd_valid_o, err_o); end
    endtask

    task automatic test_broadcast();
        set_req(1'b1, 1'b1, 0, 7, 32'h1234_5678);
        bk_rq_ready_i = 4'b0101;
        #1;
        n_vec++; if (bk_rq_valid_o !== 4'b1111 || up_rq_ready_o !== 1'b0 || bk_rq_wr_o !== 4'b1111) begin
            n_err++; $display("FAIL bc_c0 got valid=%b ready=%b wr=%b exp 1111/0/1111", bk_rq_valid_o, up_rq_ready_o, bk_rq_wr_o); end
        tick();
        bk_rq_ready_i = 4'b1010;
        #1;
        n_vec++; if (bk_rq_valid_o !== 4'b1010 || up_rq_ready_o !== 1'b1) begin
            n_err++; $display("FAIL bc_c1 got valid=%b ready=%b exp 1010/1", bk_rq_valid_o, up_rq_ready_o); end
        tick();
        bk_rq_ready_i = 4'b0000;
        #1;
        n_vec++; if (bk_rq_valid_o !== 4'b1111 || up_rq_ready_o !== 1'b0) begin
            n_err++; $display("FAIL bc_mask_back got valid=%b ready=%b exp 1111/0", bk_rq_valid_o, up_rq_ready_o); end
        // A broadcast flag on a read must be treated as a unicast read.
        bk_rq_ready_i = 4'b1111;
        set_req(1'b0, 1'b1, 2, 1, '0);
        #1;
        n_vec++; if (bk_rq_valid_o !== 4'b0100) begin n_err++; $display("FAIL bc_read_unicast got=%b exp=0100", bk_rq_valid_o); end
        up_rq_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_fifo_full();
        bk_rq_ready_i = 4'b1111;
        for (int b = 0; b < NB; b++) begin
            set_req(1'b0, 1'b0, b, b + 10, '0);
            #1;
            n_vec++; if (up_rq_ready_o !== 1'b1) begin n_err++; $display("FAIL full_fill%0d got ready=%b exp=1", b, up_rq_ready_o); end
            tick();
        end
        n_vec++; if (outstanding_o !== 3'd4) begin n_err++; $display("FAIL full_out4 got=%0d exp=4", outstanding_o); end
        set_req(1'b0, 1'b0, 0, 1, '0);
        #1;
        n_vec++; if (up_rq_ready_o !== 1'b0 || bk_rq_valid_o !== 4'b0000) begin
            n_err++; $display("FAIL full_fifth got ready=%b valid=%b exp 0/0000", up_rq_ready_o, bk_rq_valid_o); end
        up_rq_valid_i = 1'b0;
        bk_rd_valid_i = 4'b1111;
        for (int b = 0; b < NB; b++) bk_rd_data_i[b*NC +: NC] = 32'h100 + b;
        tick();
        bk_rd_valid_i = '0;
        for (int b = 0; b < NB; b++) begin
            n_vec++; if (up_rd_valid_o !== 1'b1 || up_rd_data_o !== 32'h100 + b) begin
                n_err++; $display("FAIL full_drain%0d got rdv=%b data=%h exp 1/%h", b, up_rd_valid_o, up_rd_data_o, 32'h100 + b); end
            tick();
        end
        n_vec++; if (outstanding_o !== 3'd0) begin n_err++; $display("FAIL full_out0 got=%0d exp=0", outstanding_o); end
        set_req(1'b0, 1'b0, 2, 4, '0);
        tick();
        set_req(1'b0, 1'b0, 2, 6, '0);
        #1;
        n_vec++; if (up_rq_ready_o !== 1'b0 || bk_rq_valid_o !== 4'b0000 || outstanding_o !== 3'd1) begin
            n_err++; $display("FAIL busy_block got ready=%b valid=%b out=%0d exp 0/0000/1", up_rq_ready_o, bk_rq_valid_o, outstanding_o); end
        set_req(1'b0, 1'b0, 1, 6, '0);
        #1;
        n_vec++; if (up_rq_ready_o !== 1'b1 || bk_rq_valid_o !== 4'b0010) begin
            n_err++; $display("FAIL busy_other got ready=%b valid=%b exp 1/0010", up_rq_ready_o, bk_rq_valid_o); end
        up_rq_valid_i = 1'b0;
        bk_rd_valid_i = 4'b0100;
        bk_rd_data_i[2*NC +: NC] = 32'h0000_0222;
        tick();
        bk_rd_valid_i = '0;
        n_vec++; if (up_rd_valid_o !== 1'b1 || up_rd_data_o !== 32'h0000_0222) begin
            n_err++; $display("FAIL busy_ret got rdv=%b data=%h exp 1/00000222", up_rd_valid_o, up_rd_data_o); end
        tick();
    endtask

    task automatic test_async_reset();
        bk_rq_ready_i = 4'b1111;
        set_req(1'b0, 1'b0, 0, 2, '0);
        tick();
        set_req(1'b0, 1'b0, 1, 2, '0);
        tick();
        idle_inputs();
        n_vec++; if (outstanding_o !== 3'd2) begin n_err++; $display("FAIL arst_pre got=%0d exp=2", outstanding_o); end
        #2;
        nrst = 1'b0;
        #1;
        n_vec++; if (outstanding_o !== 3'd0 || up_rd_valid_o !== 1'b0 || up_rd_data_o !== '0 || err_o !== 1'b0) begin
            n_err++; $display("FAIL arst_now got out=%0d rdv=%b data=%h err=%b exp all 0", outstanding_o, up_rd_valid_o, up_rd_data_o, err_o); end
        n_vec++; if (bk_rq_valid_o !== 4'b0000 || up_rq_ready_o !== 1'b0) begin
            n_err++; $display("FAIL arst_req got valid=%b ready=%b exp 0000/0", bk_rq_valid_o, up_rq_ready_o); end
        tick();
        nrst = 1'b1;
        tick();
        set_req(1'b0, 1'b0, 3, 0, '0);
        #1;
        n_vec++; if (up_rq_ready_o !== 1'b1) begin n_err++; $display("FAIL arst_newrd got ready=%b exp=1", up_rq_ready_o); end
        tick();
        idle_inputs();
        bk_rd_valid_i = 4'b1000;
        bk_rd_data_i[3*NC +: NC] = 32'h0000_3333;
        tick();
        bk_rd_valid_i = '0;
        n_vec++; if (up_rd_valid_o !== 1'b1 || up_rd_data_o !== 32'h0000_3333 || outstanding_o !== 3'd0) begin
            n_err++; $display("FAIL arst_ret got rdv=%b data=%h out=%0d exp 1/3333/0", up_rd_valid_o, up_rd_data_o, outstanding_o); end
        tick();
    endtask

    task automatic test_unsolicited();
        bk_rq_ready_i = 4'b1111;
        set_req(1'b0, 1'b0, 1, 8, '0);
        tick();
        idle_inputs();
        bk_rd_valid_i = 4'b0100;
        bk_rd_data_i[2*NC +: NC] = 32'hDEAD_0002;
        tick();
        bk_rd_valid_i = '0;
        n_vec++; if (err_o !== 1'b1 || up_rd_valid_o !== 1'b0) begin
            n_err++; $display("FAIL unsol_err got err=%b rdv=%b exp 1/0", err_o, up_rd_valid_o); end
        tick();
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL unsol_sticky got=%b exp=1", err_o); end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_vec++; if (err_o !== 1'b0 || outstanding_o !== 3'd0) begin
            n_err++; $display("FAIL clear got err=%b out=%0d exp 0/0", err_o, outstanding_o); end
        // The read to bank 1 was discarded by the clear, so its late return must be dropped quietly.
        bk_rd_valid_i = 4'b0010;
        bk_rd_data_i[1*NC +: NC] = 32'hDEAD_0001;
        tick();
        bk_rd_valid_i = '0;
        n_vec++; if (err_o !== 1'b0 || up_rd_valid_o !== 1'b0 || outstanding_o !== 3'd0) begin
            n_err++; $display("FAIL late_ret got err=%b rdv=%b out=%0d exp 0/0/0", err_o, up_rd_valid_o, outstanding_o); end
        tick();
    endtask

    // Random mix of reads and unicast writes, checked against a model of the
    // intended behaviour: reads retire in issue order, each bank has at most
    // one undelivered read, and at most MO reads are outstanding.
    task automatic test_random();
        int            q_bank[$];
        logic [NC-1:0] q_data[$];
        int            cd[NB];
        logic [NC-1:0] rdat[NB];
        int            bank;
        int            row;
        logic          in_q;
        logic          exp_ready;
        logic [NB-1:0] exp_valid;
        logic          acc_rd;
        int            issued;
        issued = 0;
        for (int b = 0; b < NB; b++) begin cd[b] = 0; rdat[b] = '0; end
        for (int cyc = 0; cyc < 440; cyc++) begin
            bank          = $urandom_range(0, NB - 1);
            row           = $urandom_range(0, NR - 1);
            up_rq_valid_i = (cyc < 400) && ($urandom_range(0, 3) != 0);
            up_rq_wr_i    = ($urandom_range(0, 3) == 0);
            up_bcast_i    = 1'b0;
            up_addr_i     = {bank[BW-1:0], row[RW-1:0]};
            up_wr_data_i  = $urandom();
            bk_rq_ready_i = 4'($urandom_range(0, 15));
            bk_rd_valid_i = '0;
            for (int b = 0; b < NB; b++) begin
                bk_rd_data_i[b*NC +: NC] = $urandom();
                if (cd[b] == 1) begin
                    bk_rd_valid_i[b]         = 1'b1;
                    bk_rd_data_i[b*NC +: NC] = rdat[b];
                end
            end
            #1;
            in_q = 1'b0;
            foreach (q_bank[i]) if (q_bank[i] == bank) in_q = 1'b1;
            exp_valid = '0;
            exp_ready = 1'b0;
            if (up_rq_valid_i) begin
                if (up_rq_wr_i) begin
                    exp_valid[bank] = 1'b1;
                    exp_ready       = bk_rq_ready_i[bank];
                end else if (q_bank.size() < MO && !in_q) begin
                    exp_valid[bank] = 1'b1;
                    exp_ready       = bk_rq_ready_i[bank];
                end
            end
            n_vec++; if (up_rq_ready_o !== exp_ready || bk_rq_valid_o !== exp_valid) begin
                n_err++; $display("FAIL rnd_req cyc=%0d got ready=%b valid=%b exp %b/%b", cyc, up_rq_ready_o, bk_rq_valid_o, exp_ready, exp_valid); end
            n_vec++; if (bk_addr_o !== row[RW-1:0] || bk_wr_data_o !== up_wr_data_i) begin
                n_err++; $display("FAIL rnd_route cyc=%0d got addr=%0d data=%h exp %0d/%h", cyc, bk_addr_o, bk_wr_data_o, row, up_wr_data_i); end
            acc_rd = up_rq_valid_i && !up_rq_wr_i && exp_ready;
            tick();
            for (int b = 0; b < NB; b++) if (cd[b] > 0) cd[b]--;
            if (acc_rd) begin
                rdat[bank] = $urandom();
                cd[bank]   = $urandom_range(1, 5);
                q_bank.push_back(bank);
                q_data.push_back(rdat[bank]);
                issued++;
            end
            if (up_rd_valid_o === 1'b1) begin
                n_vec++;
                if (q_bank.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious cyc=%0d got data=%h exp no return", cyc, up_rd_data_o);
                end else begin
                    if (up_rd_data_o !== q_data[0]) begin
                        n_err++; $display("FAIL rnd_data cyc=%0d bank=%0d got=%h exp=%h", cyc, q_bank[0], up_rd_data_o, q_data[0]); end
                    void'(q_bank.pop_front());
                    void'(q_data.pop_front());
                end
            end
            n_vec++; if (outstanding_o !== OW'(q_bank.size()) || err_o !== 1'b0) begin
                n_err++; $display("FAIL rnd_state cyc=%0d got out=%0d err=%b exp %0d/0", cyc, outstanding_o, err_o, q_bank.size()); end
        end
        idle_inputs();
        n_vec++; if (q_bank.size() != 0 || issued < 20) begin
            n_err++; $display("FAIL rnd_drain got undelivered=%0d issued=%0d exp 0/>=20", q_bank.size(), issued); end
    endtask

    initial begin
        test_reset();
        test_unicast_write();
        test_read_order();
        test_broadcast();
        test_fifo_full();
        test_async_reset();
        test_unsolicited();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
